// File: rtl/audio_clip_player.sv
// Clip playback engine: fetches the selected clip's PCM samples from ROM, paces them at the
// audio sample rate and offers each one to the codec serializer over a valid/ready handshake.
module audio_clip_player #(
  parameter int ADDR_W  = 20,
  parameter int DATA_W  = 16,
  parameter int CLK_DIV = 1042
) (
  input  logic                     Clk,
  input  logic                     Reset_n,
  input  logic [17:0]              InputSelect,
  output logic [4:0]               Clip_Idx,
  input  logic [ADDR_W-1:0]        Clip_Base,
  input  logic [ADDR_W-1:0]        Clip_Len,
  output logic [ADDR_W-1:0]        Rom_Addr,
  input  logic signed [DATA_W-1:0] Rom_Data,
  output logic signed [DATA_W-1:0] Sample_Out,
  output logic                     Sample_Valid,
  input  logic                     Sample_Ready,
  output logic                     End_flag
);
  localparam int                DIV_W    = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0]  DIV_ONE  = DIV_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_READ, S_PRESENT, S_PACE, S_DONE
  } state_t;

  state_t            r_state;
  logic [17:0]       r_sel;
  logic [4:0]        r_idx;
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W-1:0] r_len;
  logic [ADDR_W-1:0] r_offset;
  logic [DIV_W-1:0]  r_div;
  logic              r_pend;

  logic              w_start;
  logic              w_tick;
  logic              w_abort;
  logic              w_last;
  logic [4:0]        w_prio;
  logic [ADDR_W-1:0] w_next_off;

  function automatic logic [4:0] lowest_set(input logic [17:0] v);
    logic [4:0] idx;
    idx = '0;
    for (int i = 17; i >= 0; i--) begin
      if (v[i]) idx = 5'(i);
    end
    return idx;
  endfunction

  assign w_prio     = lowest_set(InputSelect);
  assign Clip_Idx   = (r_state == S_IDLE) ? w_prio : r_idx;
  assign w_start    = (r_state == S_IDLE) && (InputSelect != '0);
  assign w_tick     = (r_div == DIV_LAST);
  assign w_abort    = (InputSelect != r_sel);
  assign w_last     = (r_offset == r_len - ADDR_ONE);
  assign w_next_off = r_offset + ADDR_ONE;

  // Descriptor fields are plain data captured at clip start; they need no reset.
  always_ff @(posedge Clk) begin
    if (w_start) begin
      r_base <= Clip_Base;
      r_len  <= Clip_Len;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_state      <= S_IDLE;
      r_sel        <= '0;
      r_idx        <= '0;
      r_offset     <= '0;
      r_div        <= '0;
      r_pend       <= 1'b0;
      Rom_Addr     <= '0;
      Sample_Out   <= '0;
      Sample_Valid <= 1'b0;
      End_flag     <= 1'b0;
    end else begin
      End_flag <= 1'b0;
      r_div    <= w_tick ? '0 : r_div + DIV_ONE;
      // A tick that arrives while a sample is in flight is remembered (only one) for PACE.
      if (w_tick && (r_state != S_PACE)) r_pend <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_sel    <= InputSelect;
            r_idx    <= w_prio;
            r_offset <= '0;
            r_div    <= '0;
            r_pend   <= 1'b0;
            if (Clip_Len == '0) begin
              End_flag   <= 1'b1;
              Sample_Out <= '0;
              r_state    <= S_DONE;
            end else begin
              Rom_Addr <= Clip_Base;
              r_state  <= S_FETCH;
            end
          end
        end

        S_FETCH: begin
          if (w_abort) begin
            Sample_Out <= '0;
            r_state    <= S_IDLE;
          end else begin
            r_state <= S_READ;
          end
        end

        S_READ: begin
          if (w_abort) begin
            Sample_Out <= '0;
            r_state    <= S_IDLE;
          end else begin
            Sample_Out   <= Rom_Data;
            Sample_Valid <= 1'b1;
            r_state      <= S_PRESENT;
          end
        end

        S_PRESENT: begin
          // Abort waits for the handshake so an offered sample is never withdrawn.
          if (Sample_Ready) begin
            Sample_Valid <= 1'b0;
            if (w_abort) begin
              Sample_Out <= '0;
              r_state    <= S_IDLE;
            end else if (w_last) begin
              End_flag   <= 1'b1;
              Sample_Out <= '0;
              r_state    <= S_DONE;
            end else begin
              r_offset <= w_next_off;
              Rom_Addr <= r_base + w_next_off;
              r_state  <= S_PACE;
            end
          end
        end

        S_PACE: begin
          if (w_abort) begin
            Sample_Out <= '0;
            r_state    <= S_IDLE;
          end else if (w_tick || r_pend) begin
            r_pend  <= 1'b0;
            r_state <= S_FETCH;
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_audio_clip_player.sv
// Bench for audio_clip_player: random ready patterns and descriptors checked cycle by cycle
// against a timeline computed from tick times, handshake times and clip length.
module tb_audio_clip_player;
  localparam int ADDR_W  = 20;
  localparam int DATA_W  = 16;
  localparam int CLK_DIV = 8;
  localparam int MAXC    = 2048;

  logic              Clk = 1'b0;
  logic              Reset_n;
  logic [17:0]       InputSelect;
  logic [4:0]        Clip_Idx;
  logic [ADDR_W-1:0] Clip_Base;
  logic [ADDR_W-1:0] Clip_Len;
  logic [ADDR_W-1:0] Rom_Addr;
  logic [DATA_W-1:0] Rom_Data;
  logic [DATA_W-1:0] Sample_Out;
  logic              Sample_Valid;
  logic              Sample_Ready;
  logic              End_flag;

  logic [ADDR_W-1:0] tb_base [32];
  logic [ADDR_W-1:0] tb_len  [32];
  logic [15:0]       salt;
  int                n_cmp = 0;
  int                n_bad = 0;

  bit          rdy     [MAXC];
  bit          e_valid [MAXC];
  bit          e_end   [MAXC];
  logic [15:0] e_data  [MAXC];

  audio_clip_player #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CLK_DIV(CLK_DIV)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .InputSelect(InputSelect), .Clip_Idx(Clip_Idx),
    .Clip_Base(Clip_Base), .Clip_Len(Clip_Len), .Rom_Addr(Rom_Addr), .Rom_Data(Rom_Data),
    .Sample_Out(Sample_Out), .Sample_Valid(Sample_Valid), .Sample_Ready(Sample_Ready),
    .End_flag(End_flag)
  );

  always #5 Clk = ~Clk;

  function automatic logic [15:0] rom_val(input logic [ADDR_W-1:0] a);
    return a[15:0] ^ salt;
  endfunction

  // Sample ROM: data appears one cycle after the address.
  always_ff @(posedge Clk) Rom_Data <= rom_val(Rom_Addr);

  always_comb begin
    Clip_Base = tb_base[Clip_Idx];
    Clip_Len  = tb_len[Clip_Idx];
  end

  // Plays one clip (nloops times while held); cycle 0 is the first IDLE cycle seeing sel.
  // Ready pattern: mode 0 always high, mode 1 random, mode 2 low over cycles 3..22.
  task automatic run_clip(input string name, input logic [17:0] sel, input logic [ADDR_W-1:0] base,
                          input int len, input int nloops, input int mode);
    logic [17:0]       iso;
    logic [ADDR_W-1:0] a;
    int                idx, t0, f, h, ncyc;
    bit                ovf;
    iso = sel & (~sel + 18'd1);
    idx = $clog2(iso);
    tb_base[idx] = base;
    tb_len[idx]  = ADDR_W'(len);
    for (int c = 0; c < MAXC; c++) begin
      case (mode)
        0:       rdy[c] = 1'b1;
        1:       rdy[c] = ($urandom_range(0, 3) != 0);
        default: rdy[c] = !(c >= 3 && c <= 22);
      endcase
      e_valid[c] = 1'b0;
      e_end[c]   = 1'b0;
      e_data[c]  = '0;
    end
    t0  = 0;
    ovf = 1'b0;
    for (int lp = 0; lp < nloops && !ovf; lp++) begin
      if (len == 0) begin
        e_end[t0 + 1] = 1'b1;
        t0 = t0 + 2;
      end else begin
        f = t0 + 1;
        for (int k = 0; k < len && !ovf; k++) begin
          h = f + 2;
          while (h < MAXC - 4 && !rdy[h]) h++;
          if (h >= MAXC - 4) begin
            ovf = 1'b1;
          end else begin
            a = base + ADDR_W'(k);
            for (int c = f + 2; c <= h; c++) begin
              e_valid[c] = 1'b1;
              e_data[c]  = rom_val(a);
            end
            // Ticks fall at t0 + m*CLK_DIV (m >= 1); one during [f, h] is remembered.
            if (k == len - 1) begin
              e_end[h + 1] = 1'b1;
              t0 = h + 2;
            end else if ((h - t0) / CLK_DIV >= (f - t0 + CLK_DIV - 1) / CLK_DIV) begin
              f = h + 2;
            end else begin
              f = t0 + ((h - t0) / CLK_DIV + 1) * CLK_DIV + 1;
            end
          end
        end
      end
    end
    ncyc = t0;
    if (ovf) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: timeline exceeds %0d cycles (got overflow, need fit)", name, MAXC);
      return;
    end
    for (int c = 0; c <= ncyc; c++) begin
      @(negedge Clk);
      n_cmp++;
      if (Sample_Valid !== e_valid[c]) begin
        n_bad++;
        $display("FAIL %s valid c=%0d: got %b need %b", name, c, Sample_Valid, e_valid[c]);
      end
      if (e_valid[c]) begin
        n_cmp++;
        if (Sample_Out !== e_data[c]) begin
          n_bad++;
          $display("FAIL %s data c=%0d: got %h need %h", name, c, Sample_Out, e_data[c]);
        end
      end
      n_cmp++;
      if (End_flag !== e_end[c]) begin
        n_bad++;
        $display("FAIL %s end c=%0d: got %b need %b", name, c, End_flag, e_end[c]);
      end
      if (c == 0) begin
        n_cmp++;
        if (Sample_Out !== '0) begin
          n_bad++;
          $display("FAIL %s idle_sample: got %h need 0", name, Sample_Out);
        end
      end
      Sample_Ready = rdy[c];
      InputSelect  = (c < ncyc) ? sel : '0;
      if (c == 0) begin
        #1;
        n_cmp++;
        if (Clip_Idx !== 5'(idx)) begin
          n_bad++;
          $display("FAIL %s clip_idx: got %0d need %0d", name, Clip_Idx, idx);
        end
      end
    end
  endtask

  task automatic test_reset();
    tb_base[2] = 20'h02345;
    tb_len[2]  = 20'd5;
    repeat (3) begin
      @(negedge Clk);
      n_cmp++;
      if ({Rom_Addr, Sample_Out, Sample_Valid, End_flag} !== '0) begin
        n_bad++;
        $display("FAIL reset_outputs: got addr=%h smp=%h v=%b e=%b need all 0",
                 Rom_Addr, Sample_Out, Sample_Valid, End_flag);
      end
      n_cmp++;
      if (Clip_Idx !== 5'd2) begin
        n_bad++;
        $display("FAIL reset_clip_idx: got %0d need 2", Clip_Idx);
      end
    end
    Reset_n = 1'b1;
    @(negedge Clk);
    n_cmp++;
    if (Rom_Addr !== 20'h02345 || Sample_Valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_release: got addr=%h v=%b need 02345 0", Rom_Addr, Sample_Valid);
    end
    Reset_n     = 1'b0;
    InputSelect = '0;
    repeat (2) begin
      @(negedge Clk);
      n_cmp++;
      if ({Rom_Addr, Sample_Out, Sample_Valid, End_flag} !== '0) begin
        n_bad++;
        $display("FAIL reset_midclip: got addr=%h smp=%h v=%b e=%b need all 0",
                 Rom_Addr, Sample_Out, Sample_Valid, End_flag);
      end
    end
    Reset_n = 1'b1;
  endtask

  task automatic test_priority();
    logic [17:0] v, iso;
    @(negedge Clk);
    InputSelect = 18'h00600;
    #1;
    n_cmp++;
    if (Clip_Idx !== 5'd9) begin
      n_bad++;
      $display("FAIL priority_600: got %0d need 9", Clip_Idx);
    end
    InputSelect = '0;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      v   = 18'($urandom_range(1, 262143));
      iso = v & (~v + 18'd1);
      InputSelect = v;
      #1;
      n_cmp++;
      if (Clip_Idx !== 5'($clog2(iso))) begin
        n_bad++;
        $display("FAIL priority_rand %h: got %0d need %0d", v, Clip_Idx, $clog2(iso));
      end
      InputSelect = '0;
    end
  endtask

  task automatic test_abort();
    logic [ADDR_W-1:0] b10;
    salt        = 16'($urandom);
    b10         = 20'h35A00;
    tb_base[10] = b10;
    tb_len[10]  = 20'd4;
    for (int c = 0; c <= 5; c++) begin
      @(negedge Clk);
      n_cmp++;
      if (End_flag !== 1'b0) begin
        n_bad++;
        $display("FAIL abort_end c=%0d: got %b need 0", c, End_flag);
      end
      n_cmp++;
      if (Sample_Valid !== (c == 3)) begin
        n_bad++;
        $display("FAIL abort_valid c=%0d: got %b need %b", c, Sample_Valid, (c == 3));
      end
      if (c == 3) begin
        n_cmp++;
        if (Sample_Out !== rom_val(b10)) begin
          n_bad++;
          $display("FAIL abort_first: got %h need %h", Sample_Out, rom_val(b10));
        end
      end
      Sample_Ready = 1'b1;
      InputSelect  = (c == 5) ? 18'd4 : 18'd1024;
    end
    run_clip("abort_restart", 18'd4, 20'h01200, 3, 1, 0);
  endtask

  task automatic test_random();
    int                idx;
    logic [17:0]       sel;
    logic [ADDR_W-1:0] base;
    for (int i = 0; i < 8; i++) begin
      idx  = $urandom_range(0, 17);
      sel  = (18'($urandom) << idx) | (18'd1 << idx);
      base = ($urandom_range(0, 1) == 0) ? 20'hFFFFE : 20'($urandom);
      salt = 16'($urandom);
      run_clip("random", sel, base, $urandom_range(1, 5), $urandom_range(1, 2), 1);
    end
  endtask

  initial begin
    Reset_n      = 1'b0;
    InputSelect  = 18'd4;
    Sample_Ready = 1'b0;
    salt         = '0;
    for (int i = 0; i < 32; i++) begin
      tb_base[i] = '0;
      tb_len[i]  = '0;
    end
    test_reset();
    salt = '0;
    run_clip("oneshot", 18'h2, 20'h00100, 3, 1, 0);
    test_priority();
    run_clip("zero_len", 18'h20, 20'h0ABCD, 0, 1, 0);
    run_clip("zero_len_loop", 18'h20, 20'h0ABCD, 0, 2, 0);
    salt = 16'($urandom);
    run_clip("backpressure", 18'h8, 20'h04000, 3, 1, 2);
    test_abort();
    run_clip("loop", 18'd1024, 20'h007F0, 2, 3, 0);
    run_clip("wrap", 18'h1, 20'hFFFFE, 4, 1, 0);
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/audio_clip_player.md
# audio_clip_player

Sound-effect playback engine that consumes the one-hot `InputSelect` vector from the audio arbitration FSM and answers with `End_flag` when a clip finishes. It fetches 16-bit PCM samples for the selected clip from sample ROM and paces them at the audio sample rate. It hands each sample to the codec serializer over a valid/ready handshake.

## Interface
- `ADDR_W`, 20: sample ROM address width; also the width of the clip length field.
- `DATA_W`, 16: sample width.
- `CLK_DIV`, 1042: clocks per sample period (50 MHz / 48 kHz).
- `Clk` in 1: system clock; all logic is on the rising edge.
- `Reset_n` in 1: synchronous, active-low reset.
- `InputSelect` in 18: clip request vector; bit k requests clip k; all-zero means silence.
- `Clip_Idx` out 5: index into the external clip descriptor table.
- `Clip_Base` in ADDR_W: descriptor start address for `Clip_Idx`; combinational, same cycle.
- `Clip_Len` in ADDR_W: descriptor length in samples for `Clip_Idx`; combinational, same cycle.
- `Rom_Addr` out ADDR_W: sample ROM address; registered.
- `Rom_Data` in DATA_W: sample ROM data; valid exactly 1 cycle after `Rom_Addr`.
- `Sample_Out` out DATA_W: current sample, two's complement.
- `Sample_Valid` out 1: `Sample_Out` is offered to the codec.
- `Sample_Ready` in 1: codec accepts the sample.
- `End_flag` out 1: one-cycle pulse on normal clip completion.

## Operation
- Select decode: the lowest set bit of `InputSelect` wins. In IDLE, `Clip_Idx` is the combinational priority encode of `InputSelect`. In all other states, `Clip_Idx` is the latched index.
- States:
  - IDLE: if `InputSelect` != 0, latch `sel` (the raw vector), the index, `Clip_Base` and `Clip_Len`. Clear `offset` and the divider. If `Clip_Len`==0, go to DONE; otherwise load `Rom_Addr`=`Clip_Base` and go to FETCH.
  - FETCH: wait one cycle for ROM latency, then go to READ.
  - READ: register `Rom_Data` into `Sample_Out`, set `Sample_Valid`=1, go to PRESENT.
  - PRESENT: hold `Sample_Out` and `Sample_Valid` stable until `Sample_Ready`. On handshake: clear `Sample_Valid`. If `offset`==len-1, go to DONE. Otherwise increment `offset`, load `Rom_Addr`=base+offset+1 (mod 2^ADDR_W), and go to PACE.
  - PACE: on a tick, or if the tick-pending flag is set, clear the flag and go to FETCH.
  - DONE: `End_flag`=1 and `Sample_Out`=0; go to IDLE.
- Divider: counts 0..CLK_DIV-1 and wraps. It produces a tick when the count equals CLK_DIV-1. It is cleared at clip start.
  - A tick occurring outside PACE sets the tick-pending flag.
  - Further ticks while the flag is already set are dropped (at most one pending).
- Abort: in FETCH, READ or PACE, if `InputSelect` != `sel`, go to IDLE next cycle. `Sample_Out` becomes 0 and no `End_flag` is issued.
  - In PRESENT, abort is taken only on the handshake cycle, instead of the normal transition, so valid never drops unaccepted.
- Looping: after DONE, IDLE restarts immediately if `InputSelect` is still nonzero. Held music therefore loops with a gap of 3 cycles plus the handshake.
- Sample addressing: `offset` < len always. Addresses wrap modulo 2^ADDR_W. No arithmetic saturation.

## Timing
- Reset (`Reset_n`=0 at an edge): state IDLE; `Rom_Addr`=0, `Sample_Out`=0, `Sample_Valid`=0, `End_flag`=0, `offset`=0, divider=0, pending=0. Reset mid-clip abandons the clip silently.
- Start latency: request seen in IDLE at cycle 0 → `Rom_Addr`=base in cycle 1 → `Sample_Valid`=1 from cycle 3.
- Sample spacing: first sample immediate; each later sample is fetched on the next divider tick after the previous handshake. With `Sample_Ready` tied high, `Sample_Valid` rises every CLK_DIV cycles.
- `End_flag`: the cycle after the last handshake; exactly one cycle wide.
- The upstream FSM drops `InputSelect` one cycle after `End_flag`, while the block is in IDLE, so no retrigger occurs.

## Test plan
- Reset: hold `Reset_n`=0 with `InputSelect`=4 → all outputs 0 and no ROM activity; release → `Rom_Addr`=base one cycle later.
- One-shot, CLK_DIV=8, clip 1 base=0x100 len=3, ROM data = address, Ready=1 → `Sample_Out` 0x100, 0x101, 0x102 on valids spaced 8 cycles apart; `End_flag` pulses once after the third sample.
- Priority and zero-length: `InputSelect`=0x600 → `Clip_Idx`=9. Clip with len=0 → `End_flag` on the cycle after IDLE, no valid.
- Backpressure: Ready low for 20 cycles with CLK_DIV=8 → `Sample_Out` held stable throughout; the next sample is fetched immediately after the handshake via the pending flag.
- Abort: `InputSelect` 1024→4 while in PACE → IDLE, `Sample_Out`=0, no `End_flag`, then clip 2 starts.
- Loop: hold `InputSelect`=1024 with len=2 → `End_flag` pulses every loop and playback restarts from base with no idle beyond 3 cycles plus the handshake.
